shift_div_hs: RTL and testbench

//  Iterative restoring divider with valid/ready handshakes. It succeeds the

---
 rtl/shift_div_pkg.sv | 25 ++
 rtl/shift_div_hs_div_step.sv | 42 ++++
 rtl/shift_div_hs.sv | 163 ++++++++++++++++
 tb/tb_shift_div_hs.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_div_pkg.sv
// Shared definitions for the handshaked shift divider.
//   state_t    : controller states, IDLE -> PREP -> CALC -> FIX -> DONE
//   iter_count : number of CALC cycles for a given width / bits-per-cycle
//   cnt_width  : width of the down-counter that can hold iter_count
// Divide-by-zero result rule: the quotient saturates to all ones and the
// remainder returns the original (unmodified) dividend.
package shift_div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    function automatic int iter_count(input int bits, input int bpc);
        return bits / bpc;
    endfunction

    function automatic int cnt_width(input int bits, input int bpc);
        return $clog2(bits / bpc + 1);
    endfunction

endpackage

// File: rtl/shift_div_hs_div_step.sv
// div_step: BPC chained restoring-division steps, purely combinational.
//   rem      : current partial remainder (always below the divisor)
//   divisor  : divisor magnitude
//   dvd_bits : next BPC dividend bits, MSB first
//   rem_next : partial remainder after BPC steps
//   q_bits   : the BPC quotient bits resolved by these steps
module div_step #(
    parameter int BITS = 48,
    parameter int BPC  = 1
) (
    input  logic [BITS-1:0] rem,
    input  logic [BITS-1:0] divisor,
    input  logic [BPC-1:0]  dvd_bits,
    output logic [BITS-1:0] rem_next,
    output logic [BPC-1:0]  q_bits
);

    // One bit wider than the operands: shifting in a dividend bit can
    // momentarily exceed BITS bits before the trial subtraction.
    logic [BITS:0]   trial;
    logic [BITS-1:0] work;

    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves one unassigned, which would otherwise infer a latch.
        work   = rem;
        trial  = '0;
        q_bits = '0;
        // NOTE: blocking assignments here on purpose -- each step must see
        // the remainder produced by the step before it in the same cycle.
        for (int i = BPC - 1; i >= 0; i--) begin
            trial = {work, dvd_bits[i]};
            if (trial >= {1'b0, divisor}) begin
                trial     = trial - {1'b0, divisor};
                q_bits[i] = 1'b1;
            end
            work = trial[BITS-1:0];
        end
        rem_next = work;
    end

endmodule

// File: rtl/shift_div_hs.sv
// shift_div_hs: iterative restoring divider with valid/ready handshakes.
// One operation in flight; the result is held on out_* until consumed and
// stays on the outputs afterwards until the next result is written.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand handshake (ready only while IDLE)
//   in_signed         : 1 = two's-complement divide, 0 = unsigned
//   in_a, in_b, in_tag: dividend, divisor, opaque tag
//   out_valid/out_ready: result handshake (valid while DONE)
//   out_q, out_r, out_tag: quotient, remainder, tag of the operation
//   out_div0, out_ovf : divisor was zero / signed MIN / -1
module shift_div_hs
    import shift_div_pkg::*;
#(
    parameter int BITS  = 48,
    parameter int BPC   = 1,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [BITS-1:0]  in_a,
    input  logic [BITS-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BITS-1:0]  out_q,
    output logic [BITS-1:0]  out_r,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_div0,
    output logic             out_ovf
);

    localparam int ITER = iter_count(BITS, BPC);
    localparam int CW   = cnt_width(BITS, BPC);
    localparam logic [BITS-1:0] MIN_VAL = {1'b1, {(BITS - 1){1'b0}}};

    if ((BITS % BPC) != 0 || !(BPC == 1 || BPC == 2 || BPC == 4)) begin : g_bad_params
        $error("shift_div_hs: BITS must be a multiple of BPC, and BPC one of 1, 2, 4");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [BITS-1:0]  a_raw, b_raw;   // operands as received
    logic [BITS-1:0]  dvd;            // dividend magnitude, becomes quotient
    logic [BITS-1:0]  dvs;            // divisor magnitude
    logic [BITS-1:0]  rem;            // partial remainder
    logic             op_signed, sign_q, sign_r, div0, ovf;
    logic [TAG_W-1:0] tag;

    logic [BITS-1:0]  rem_next;
    logic [BPC-1:0]   q_bits;
    logic [BITS-1:0]  q_fix, r_fix;
    logic             a_neg, b_neg;

    assign in_ready = (state == ST_IDLE) && !rst;
    assign a_neg    = op_signed & a_raw[BITS-1];
    assign b_neg    = op_signed & b_raw[BITS-1];

    div_step #(
        .BITS (BITS),
        .BPC  (BPC)
    ) u_step (
        .rem      (rem),
        .divisor  (dvs),
        .dvd_bits (dvd[BITS-1 -: BPC]),
        .rem_next (rem_next),
        .q_bits   (q_bits)
    );

    // Sign correction gives truncation toward zero with the remainder
    // following the dividend; div0 and overflow override the raw result.
    always_comb begin
        q_fix = sign_q ? -dvd : dvd;
        r_fix = sign_r ? -rem : rem;
        if (ovf) begin
            q_fix = MIN_VAL;
            r_fix = '0;
        end
        if (div0) begin
            q_fix = '1;
            r_fix = a_raw;
        end
    end

    // Controller and result registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_q     <= '0;
            out_r     <= '0;
            out_tag   <= '0;
            out_div0  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) state <= ST_PREP;
                end
                ST_PREP: begin
                    cnt   <= CW'(ITER);
                    state <= ST_CALC;
                end
                ST_CALC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= ST_FIX;
                end
                ST_FIX: begin
                    out_q     <= q_fix;
                    out_r     <= r_fix;
                    out_tag   <= tag;
                    out_div0  <= div0;
                    out_ovf   <= ovf;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operand datapath.
    // NOTE: no reset here -- every register is written before it is read in
    // each operation, so clearing it would only cost reset routing.
    always_ff @(posedge clk) begin
        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    a_raw     <= in_a;
                    b_raw     <= in_b;
                    op_signed <= in_signed;
                    tag       <= in_tag;
                end
            end
            ST_PREP: begin
                dvd    <= a_neg ? -a_raw : a_raw;
                dvs    <= b_neg ? -b_raw : b_raw;
                sign_q <= a_neg ^ b_neg;
                sign_r <= a_neg;
                div0   <= (b_raw == '0);
                ovf    <= op_signed && (a_raw == MIN_VAL) && (b_raw == '1);
                rem    <= '0;
            end
            ST_CALC: begin
                rem <= rem_next;
                dvd <= (dvd << BPC) | BITS'(q_bits);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shift_div_hs.sv
// Self-checking bench for shift_div_hs: a BPC=1 instance for directed cases
// and a BPC=4 instance for a randomised stream against a behavioural model.
module tb_shift_div_hs;

    localparam int BITS  = 48;
    localparam int TAG_W = 4;
    localparam int LAT1  = 48 + 3;
    localparam int LAT4  = 12 + 3;
    localparam logic [BITS-1:0] MIN_VAL = {1'b1, {(BITS - 1){1'b0}}};

    typedef struct {
        logic [BITS-1:0]  q;
        logic [BITS-1:0]  r;
        logic [TAG_W-1:0] tag;
        logic             div0;
        logic             ovf;
        int               acc;
    } exp_t;

    exp_t sb1[$];
    exp_t sb4[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic             in_valid_1, in_ready_1, in_signed_1, out_valid_1, out_ready_1;
    logic [BITS-1:0]  in_a_1, in_b_1, out_q_1, out_r_1;
    logic [TAG_W-1:0] in_tag_1, out_tag_1;
    logic             out_div0_1, out_ovf_1;

    logic             in_valid_4, in_ready_4, in_signed_4, out_valid_4, out_ready_4;
    logic [BITS-1:0]  in_a_4, in_b_4, out_q_4, out_r_4;
    logic [TAG_W-1:0] in_tag_4, out_tag_4;
    logic             out_div0_4, out_ovf_4;

    shift_div_hs #(.BITS(BITS), .BPC(1), .TAG_W(TAG_W)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_1), .in_ready(in_ready_1), .in_signed(in_signed_1),
        .in_a(in_a_1), .in_b(in_b_1), .in_tag(in_tag_1),
        .out_valid(out_valid_1), .out_ready(out_ready_1),
        .out_q(out_q_1), .out_r(out_r_1), .out_tag(out_tag_1),
        .out_div0(out_div0_1), .out_ovf(out_ovf_1)
    );

    shift_div_hs #(.BITS(BITS), .BPC(4), .TAG_W(TAG_W)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_4), .in_ready(in_ready_4), .in_signed(in_signed_4),
        .in_a(in_a_4), .in_b(in_b_4), .in_tag(in_tag_4),
        .out_valid(out_valid_4), .out_ready(out_ready_4),
        .out_q(out_q_4), .out_r(out_r_4), .out_tag(out_tag_4),
        .out_div0(out_div0_4), .out_ovf(out_ovf_4)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic sgn, input logic [BITS-1:0] a,
                                   input logic [BITS-1:0] b, input logic [TAG_W-1:0] tag);
        exp_t e;
        e.tag  = tag;
        e.div0 = 1'b0;
        e.ovf  = 1'b0;
        e.acc  = 0;
        if (b == '0) begin
            e.div0 = 1'b1;
            e.q    = '1;
            e.r    = a;
        end else if (sgn && a == MIN_VAL && b == '1) begin
            e.ovf = 1'b1;
            e.q   = MIN_VAL;
            e.r   = '0;
        end else if (sgn) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    function automatic logic [BITS-1:0] rnd48();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[BITS-1:0];
    endfunction

    // Called at a falling edge; leaves with the operation accepted.
    task automatic send1(input logic sgn, input logic [BITS-1:0] a,
                         input logic [BITS-1:0] b, input logic [TAG_W-1:0] tag);
        exp_t e;
        int   w = 0;
        while (!in_ready_1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready_1) begin
            check("send1_ready_timeout", 64'd0, 64'd1);
            return;
        end
        in_valid_1  = 1'b1;
        in_signed_1 = sgn;
        in_a_1      = a;
        in_b_1      = b;
        in_tag_1    = tag;
        e = model(sgn, a, b, tag);
        @(negedge clk);
        in_valid_1 = 1'b0;
        e.acc = cyc;
        sb1.push_back(e);
    endtask

    // Waits for the result, compares it, optionally holds off out_ready for
    // `hold` cycles while poking in_valid, then completes the handshake.
    task automatic recv1(input int hold);
        exp_t e;
        int   w = 0;
        while (!out_valid_1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid_1) begin
            check("recv1_timeout", 64'd0, 64'd1);
            return;
        end
        if (sb1.size() == 0) begin
            check("sb1_empty", 64'd0, 64'd1);
            return;
        end
        e = sb1.pop_front();
        check("lat1", 64'(cyc - e.acc + 1), 64'(LAT1));
        check("q1", out_q_1, e.q);
        check("r1", out_r_1, e.r);
        check("tag1", out_tag_1, e.tag);
        check("div0_1", out_div0_1, e.div0);
        check("ovf1", out_ovf_1, e.ovf);
        for (int i = 0; i < hold; i++) begin
            in_valid_1  = 1'b1;
            in_signed_1 = 1'b0;
            in_a_1      = rnd48();
            in_b_1      = 48'd3;
            in_tag_1    = 4'hF;
            @(negedge clk);
            check("bp_valid", out_valid_1, 1'b1);
            check("bp_busy_ready", in_ready_1, 1'b0);
            check("bp_q", out_q_1, e.q);
            check("bp_r", out_r_1, e.r);
            check("bp_tag", out_tag_1, e.tag);
        end
        in_valid_1  = 1'b0;
        out_ready_1 = 1'b1;
        @(negedge clk);
        out_ready_1 = 1'b0;
        check("release_valid", out_valid_1, 1'b0);
        check("release_ready", in_ready_1, 1'b1);
        check("hold_q_after", out_q_1, e.q);
        check("hold_tag_after", out_tag_1, e.tag);
    endtask

    task automatic producer4();
        exp_t            e;
        logic            sgn;
        logic [BITS-1:0] a, b;
        for (int i = 0; i < 1000; i++) begin
            int w = 0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            while (!in_ready_4 && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready_4) begin
                check("send4_ready_timeout", 64'd0, 64'd1);
                break;
            end
            sgn = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 15) == 0) ? MIN_VAL : rnd48();
            case ($urandom_range(0, 15))
                0:       b = '0;
                1:       b = '1;
                default: b = rnd48() >> $urandom_range(0, 47);
            endcase
            in_valid_4  = 1'b1;
            in_signed_4 = sgn;
            in_a_4      = a;
            in_b_4      = b;
            in_tag_4    = TAG_W'(i);
            e     = model(sgn, a, b, TAG_W'(i));
            e.acc = cyc + 1;
            sb4.push_back(e);
            @(negedge clk);
            in_valid_4 = 1'b0;
        end
    endtask

    task automatic consumer4();
        exp_t e;
        int   n     = 0;
        int   guard = 0;
        while (n < 1000 && guard < 60000) begin
            @(negedge clk);
            guard++;
            if (out_valid_4) begin
                if (sb4.size() == 0) begin
                    check("sb4_empty", 64'd0, 64'd1);
                end else begin
                    e = sb4.pop_front();
                    check("lat4", 64'(cyc - e.acc + 1), 64'(LAT4));
                    check("q4", out_q_4, e.q);
                    check("r4", out_r_4, e.r);
                    check("tag4", out_tag_4, e.tag);
                    check("div0_4", out_div0_4, e.div0);
                    check("ovf4", out_ovf_4, e.ovf);
                end
                n++;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                out_ready_4 = 1'b1;
                @(negedge clk);
                out_ready_4 = 1'b0;
                check("release4_valid", out_valid_4, 1'b0);
            end
        end
        check("rx4_count", 64'(n), 64'd1000);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid_1  = 1'b0; in_signed_1 = 1'b0; in_a_1 = '0; in_b_1 = '0; in_tag_1 = '0;
        out_ready_1 = 1'b0;
        in_valid_4  = 1'b0; in_signed_4 = 1'b0; in_a_4 = '0; in_b_4 = '0; in_tag_4 = '0;
        out_ready_4 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_ready", in_ready_1, 1'b0);
        check("rst_valid", out_valid_1, 1'b0);
        check("rst_q", out_q_1, '0);
        check("rst_r", out_r_1, '0);
        check("rst_tag", out_tag_1, '0);
        check("rst_div0", out_div0_1, 1'b0);
        check("rst_ovf", out_ovf_1, 1'b0);
        check("rst_valid4", out_valid_4, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", in_ready_1, 1'b1);

        // Unsigned and signed basics.
        send1(1'b0, 48'd100, 48'd7, 4'h1);              recv1(0);
        send1(1'b1, BITS'(-100), 48'd7, 4'h2);          recv1(0);
        send1(1'b1, 48'd100, BITS'(-7), 4'h3);          recv1(0);
        send1(1'b1, BITS'(-100), BITS'(-7), 4'h4);      recv1(0);

        // Divide by zero, signed overflow.
        send1(1'b1, 48'd12345, 48'd0, 4'h5);            recv1(0);
        send1(1'b0, 48'd12345, 48'd0, 4'h6);            recv1(0);
        send1(1'b1, MIN_VAL, '1, 4'h7);                 recv1(0);
        send1(1'b0, MIN_VAL, '1, 4'h8);                 recv1(0);

        // Backpressure with in_valid asserted while busy; the next op goes
        // in on the cycle right after the release.
        send1(1'b0, 48'hABCD_1234_5678, 48'd37, 4'h9);  recv1(10);
        send1(1'b1, BITS'(-1), 48'd2, 4'hA);            recv1(0);

        // Reset in the middle of CALC discards the operation.
        send1(1'b0, 48'd1000, 48'd3, 4'hB);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", out_valid_1, 1'b0);
        check("midrst_ready", in_ready_1, 1'b0);
        check("midrst_q", out_q_1, '0);
        check("midrst_tag", out_tag_1, '0);
        rst = 1'b0;
        sb1.delete();
        @(negedge clk);
        check("midrst_ready_after", in_ready_1, 1'b1);
        check("midrst_valid_after", out_valid_1, 1'b0);
        send1(1'b0, 48'd81, 48'd9, 4'hC);               recv1(0);

        // Randomised stream on the 4-bits-per-cycle instance.
        fork
            producer4();
            consumer4();
        join
        check("sb4_drained", 64'(sb4.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
